// File: rtl/kbd_event_decoder.sv
// PS/2 scancode stream decoder: make/break/E0/E1 parsing, modifier and caps tracking,
// typematic repeat suppression, and a first-word-fall-through event FIFO.
module kbd_event_decoder #(
   parameter int FIFO_DEPTH      = 8,
   parameter bit REPORT_BREAK    = 1'b1,
   parameter bit SUPPRESS_REPEAT = 1'b1,
   localparam int AW             = $clog2(FIFO_DEPTH),
   localparam int CW             = AW + 1
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          code_valid,
   input  logic [7:0]    code,
   input  logic          ev_rd,
   output logic          ev_valid,
   output logic [13:0]   ev_data,
   output logic [CW-1:0] ev_count,
   output logic          overflow,
   output logic [3:0]    mods,
   output logic [7:0]    held_key,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EXT     = 3'd1,
      S_BRK     = 3'd2,
      S_EXT_BRK = 3'd3,
      S_SKIP    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        dec_make, dec_brk, dec_ext;

   // Handshake: a byte is consumed on every clk edge where code_valid=1; an event
   // is popped on every edge where ev_rd=1 and ev_valid=1, otherwise ev_rd is ignored.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dec_make = 1'b0;
      dec_brk  = 1'b0;
      dec_ext  = 1'b0;
      if (code_valid) begin
         case (state_q)
            S_IDLE: begin
               if (code == 8'hE0) state_d = S_EXT;
               else if (code == 8'hF0) state_d = S_BRK;
               else if (code == 8'hE1) begin
                  state_d = S_SKIP;
                  cnt_d   = 3'd7;
               end else if (!(code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                  dec_make = 1'b1;
               end
            end
            S_EXT: begin
               if (code == 8'hF0) state_d = S_EXT_BRK;
               else if (code == 8'hE0) state_d = S_EXT;
               else if (code == 8'hE1) begin
                  state_d = S_SKIP;
                  cnt_d   = 3'd7;
               end else begin
                  dec_make = 1'b1;
                  dec_ext  = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_BRK: begin
               dec_brk = 1'b1;
               state_d = S_IDLE;
            end
            S_EXT_BRK: begin
               dec_brk = 1'b1;
               dec_ext = 1'b1;
               state_d = S_IDLE;
            end
            S_SKIP: begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Key bookkeeping; mod flops: [0] lshift [1] rshift [2] lctrl [3] rctrl [4] lalt [5] ralt
   logic [5:0]  mod_q, mod_d, mod_sel;
   logic        caps_q, caps_d;
   logic        rec_ext_q, rec_ext_d, rec_held_q, rec_held_d;
   logic [7:0]  rec_code_q, rec_code_d, held_q, held_d;
   logic        fake, rec_match, make_ok, brk_ok, push;
   logic [13:0] ev_word;

   always_comb begin
      mod_sel[0] = !dec_ext && (code == 8'h12);
      mod_sel[1] = !dec_ext && (code == 8'h59);
      mod_sel[2] = !dec_ext && (code == 8'h14);
      mod_sel[3] =  dec_ext && (code == 8'h14);
      mod_sel[4] = !dec_ext && (code == 8'h11);
      mod_sel[5] =  dec_ext && (code == 8'h11);
      fake       = dec_ext && ((code == 8'h12) || (code == 8'h59));
      rec_match  = (rec_ext_q == dec_ext) && (rec_code_q == code);
      make_ok    = dec_make && !fake && !(SUPPRESS_REPEAT && rec_held_q && rec_match);
      brk_ok     = dec_brk && !fake;

      mod_d      = mod_q;
      caps_d     = caps_q;
      rec_ext_d  = rec_ext_q;
      rec_code_d = rec_code_q;
      rec_held_d = rec_held_q;
      held_d     = held_q;
      if (make_ok) begin
         mod_d      = mod_q | mod_sel;
         caps_d     = caps_q ^ (code == 8'h58);
         rec_ext_d  = dec_ext;
         rec_code_d = code;
         rec_held_d = 1'b1;
         held_d     = code;
      end
      if (brk_ok) begin
         mod_d = mod_q & ~mod_sel;
         if (rec_match) begin
            rec_held_d = 1'b0;
            held_d     = 8'h00;
         end
      end
      // Modifier fields report the state after this event has been applied.
      ev_word = {dec_brk, dec_ext, caps_d, mod_d[5] | mod_d[4], mod_d[3] | mod_d[2],
                 mod_d[1] | mod_d[0], code};
      push    = make_ok || (brk_ok && REPORT_BREAK);
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         mod_q      <= 6'd0;
         caps_q     <= 1'b0;
         rec_ext_q  <= 1'b0;
         rec_code_q <= 8'h00;
         rec_held_q <= 1'b0;
         held_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mod_q      <= mod_d;
         caps_q     <= caps_d;
         rec_ext_q  <= rec_ext_d;
         rec_code_q <= rec_code_d;
         rec_held_q <= rec_held_d;
         held_q     <= held_d;
      end
   end

   // Event FIFO; a full FIFO still accepts a push when a pop happens on the same edge.
   logic [13:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d, full, pop, wr_en;

   always_comb begin
      full    = (count_q == CW'(FIFO_DEPTH));
      pop     = ev_rd && (count_q != '0);
      wr_en   = push && (!full || pop);
      ovf_d   = ovf_q | (push && full && !pop);
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr_en) wr_q <= wr_q + AW'(1);
         if (pop)   rd_q <= rd_q + AW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= ev_word;
   end

   assign ev_valid  = (count_q != '0);
   assign ev_data   = ev_valid ? mem_q[rd_q] : 14'h0000;
   assign ev_count  = count_q;
   assign overflow  = ovf_q;
   assign mods      = {caps_q, mod_q[5] | mod_q[4], mod_q[3] | mod_q[2], mod_q[1] | mod_q[0]};
   assign held_key  = held_q;
   assign dbg_state = state_q;

endmodule

// File: doc/kbd_event_decoder.md
Name: kbd_event_decoder

Overview:
- Successor to the single-key PS/2 keyboard front end. It consumes the byte stream from ps2_keyboard and decodes make/break/extended prefixes, including the Pause (E1) sequence.
- Tracks left/right modifier state and caps lock, and can suppress typematic repeats.
- Queues timestamp-free key events in a parametrised first-word-fall-through FIFO, so software can read every keystroke, not only the currently held key.
- ASCII mapping stays downstream (scancode_to_ascii), driven from ev_data fields.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
- REPORT_BREAK, 1, 1 = push break events, 0 = breaks only update state.
- SUPPRESS_REPEAT, 1, 1 = drop a make identical to the currently held key (typematic).

Ports:
- clk  in  1  system clock
- clrn  in  1  synchronous active-low reset
- code_valid  in  1  one-cycle strobe: code holds a new scancode byte
- code  in  8  scancode byte from ps2_keyboard
- ev_rd  in  1  pop FIFO head when ev_valid=1
- ev_valid  out  1  FIFO not empty
- ev_data  out  14  head event: [13] brk, [12] ext, [11] caps, [10] alt, [9] ctrl, [8] shift, [7:0] scancode
- ev_count  out  $clog2(FIFO_DEPTH)+1  entries stored
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- mods  out  4  live {caps, alt, ctrl, shift}
- held_key  out  8  scancode of most recent un-released make; 0 if none

Behaviour:
- Reset (clrn=0 at a clk edge):
  - All outputs are 0; FIFO is emptied.
  - Parser returns to IDLE; modifier flops, caps, last-make record and skip counter are cleared.
  - Applies mid-sequence too (e.g. after E0, or inside Pause).
- Parser states, advanced only on code_valid:
  - IDLE: E0→EXT; F0→BRK; E1→SKIP with cnt=7; AA/FA/EE/FE/00/FF are discarded and stay IDLE; any other byte is a make (ext=0).
  - EXT: F0→EXT_BRK; E0/E1 restart as from IDLE; other byte is a make (ext=1)→IDLE.
  - BRK: byte is a break (ext=0)→IDLE.
  - EXT_BRK: byte is a break (ext=1)→IDLE.
  - SKIP: decrement cnt per byte; at cnt reaching 0 go to IDLE. No events and no state change for the whole Pause sequence.
- Modifier tracking uses separate flops:
  - lshift=12, rshift=59 (ext=0).
  - lctrl=14, rctrl=E0 14.
  - lalt=11, ralt=E0 11.
  - Make sets the flop, break clears it.
  - shift/ctrl/alt outputs are the OR of their left/right flops.
  - E0 12 and E0 59 (fake shifts) are ignored entirely: no event, no state change.
- Caps lock: toggles on an accepted (non-suppressed) make of 58; break of 58 has no effect on caps.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - The last accepted make is recorded as {ext, code, held=1}.
  - A make equal to the recorded {ext, code} while held=1 is dropped: no push, no caps toggle.
  - A break matching the record clears held.
  - A make of a different key overwrites the record.
  - With SUPPRESS_REPEAT=0, every make is accepted.
- held_key: set to code on an accepted make; cleared to 0 on a break whose {ext, code} matches the record.
- Event fields: brk/ext/code come from the decoded byte. Modifier fields carry state after this event is applied, so a shift make reports shift=1 and a shift break reports shift=0.
- Push timing:
  - A decoded event is written on the clk edge that samples code_valid.
  - ev_valid/ev_data reflect it in the next cycle (1-cycle latency).
  - Breaks are pushed only if REPORT_BREAK=1.
- FIFO rules:
  - ev_data always shows the head.
  - ev_rd with ev_valid=0 is ignored.
  - Push when full: the event is dropped and overflow is set. Decoder state (modifiers, caps, held) still updates.
  - Push and pop in the same cycle: both occur, count unchanged, including when full or when a single entry is present.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - overflow clears only on reset.
- code_valid is never asserted in consecutive cycles by ps2_keyboard. The block still accepts back-to-back strobes, one byte per cycle.

Test Plan:
- Bytes 1C, F0 1C → events 0x001C then 0x201C; held_key 1C then 00; ev_count 2.
- Bytes 12, 1C, 1C, 1C, F0 1C, F0 12 (SUPPRESS_REPEAT=1) → four events only: 0x0112, 0x011C, 0x211C, 0x2012; mods shift returns to 0.
- Bytes 58, F0 58, 58 → caps toggles 1 then 0; events 0x0858, 0x2858, 0x0058; E0 14 with 14 held, then releasing only 14 → ctrl stays 1.
- Bytes E1 14 77 E1 F0 14 F0 77, then 1C → exactly one event, 0x001C. Reset asserted after E0 then byte 75 → 0x0075 with ext=0.
- FIFO_DEPTH=8: nine makes with no reads → ev_count 8, overflow=1, head is the first event. Pop plus new make in the same cycle → count stays 8, overflow unchanged.
- REPORT_BREAK=0: bytes 1C, F0 1C → one event 0x001C; held_key returns to 00.
